// File: rtl/hephaestus_exec_datapath_if.sv
// Bus between the Hephaestus control FSM and the execution datapath.
// The master is the control FSM; the slave is the datapath.
interface hephaestus_exec_datapath_if;
  logic       read_en;
  logic       write_en;
  logic       write_high;
  logic [2:0] ra_num;
  logic [2:0] rb_num;
  logic [2:0] rc_num;
  logic [7:0] rc_in;
  logic [7:0] mul_high_in;
  logic [7:0] ra_data;
  logic [7:0] rb_data;

  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic [3:0] alu_fsl;
  logic [7:0] result_low;
  logic [7:0] mul_high;
  logic [3:0] alu_sreg;

  logic       jump;
  logic       hold;
  logic [7:0] jump_line;
  logic [7:0] pc_current;
  logic [7:0] pc_next;

  modport master (
    output read_en, write_en, write_high, ra_num, rb_num, rc_num, rc_in, mul_high_in,
    output operand_a, operand_b, alu_fsl,
    output jump, hold, jump_line,
    input  ra_data, rb_data, result_low, mul_high, alu_sreg, pc_current, pc_next
  );

  modport slave (
    input  read_en, write_en, write_high, ra_num, rb_num, rc_num, rc_in, mul_high_in,
    input  operand_a, operand_b, alu_fsl,
    input  jump, hold, jump_line,
    output ra_data, rb_data, result_low, mul_high, alu_sreg, pc_current, pc_next
  );
endinterface

// File: rtl/hephaestus_exec_datapath.sv
// Hephaestus execution datapath: 8x8 register file with registered read ports,
// combinational 16-function ALU with {C,Z,N,V} flags, and the program counter.
module hephaestus_exec_datapath (
  input logic                      clk,
  input logic                      rst,
  hephaestus_exec_datapath_if.slave dp
);

  localparam logic [3:0] FN_ADD  = 4'h0;
  localparam logic [3:0] FN_SUB  = 4'h1;
  localparam logic [3:0] FN_MUL  = 4'h2;
  localparam logic [3:0] FN_AND  = 4'h3;
  localparam logic [3:0] FN_OR   = 4'h4;
  localparam logic [3:0] FN_XOR  = 4'h5;
  localparam logic [3:0] FN_NOT  = 4'h6;
  localparam logic [3:0] FN_NAND = 4'h7;
  localparam logic [3:0] FN_NOR  = 4'h8;
  localparam logic [3:0] FN_XNOR = 4'h9;
  localparam logic [3:0] FN_SHL  = 4'hA;
  localparam logic [3:0] FN_SHR  = 4'hB;
  localparam logic [3:0] FN_INC  = 4'hC;
  localparam logic [3:0] FN_DEC  = 4'hD;
  localparam logic [3:0] FN_CMP  = 4'hE;
  localparam logic [3:0] FN_PASS = 4'hF;

  // Two's-complement overflow: true result leaves the signed 8-bit range.
  function automatic logic addOvf(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [8:0] s;
    s = a + b;
    return (s > 9'sd127) || (s < -9'sd128);
  endfunction

  function automatic logic subOvf(input logic signed [7:0] a, input logic signed [7:0] b);
    logic signed [8:0] s;
    s = a - b;
    return (s > 9'sd127) || (s < -9'sd128);
  endfunction

  // ---------------------------------------------------------------------------
  // Register file: write and read sampled on the same edge, so a read of the
  // index being written returns the pre-write contents.
  // ---------------------------------------------------------------------------
  logic [7:0] gpr [8];
  logic [7:0] raData_p1;
  logic [7:0] rbData_p1;
  logic [2:0] rcHighNum;

  assign rcHighNum = dp.rc_num + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) gpr[i] <= '0;
      raData_p1 <= '0;
      rbData_p1 <= '0;
    end else begin
      if (dp.write_en) begin
        gpr[dp.rc_num] <= dp.rc_in;
        if (dp.write_high) gpr[rcHighNum] <= dp.mul_high_in;
      end
      if (dp.read_en) begin
        raData_p1 <= gpr[dp.ra_num];
        rbData_p1 <= gpr[dp.rb_num];
      end
    end
  end

  assign dp.ra_data = raData_p1;
  assign dp.rb_data = rbData_p1;

  // ---------------------------------------------------------------------------
  // ALU (combinational)
  // ---------------------------------------------------------------------------
  logic [7:0]  opA;
  logic [7:0]  opB;
  logic [8:0]  sumU;
  logic [8:0]  diffU;
  logic [15:0] r16;
  logic        flagC;
  logic        flagZ;
  logic        flagN;
  logic        flagV;

  assign opA = dp.operand_a;
  assign opB = dp.operand_b;

  always_comb begin
    r16   = '0;
    flagC = 1'b0;
    flagV = 1'b0;
    sumU  = {1'b0, opA} + {1'b0, opB};
    // Bit 8 of the 9-bit difference is the unsigned borrow (A<B).
    diffU = {1'b0, opA} - {1'b0, opB};
    case (dp.alu_fsl)
      FN_ADD: begin
        r16[7:0] = sumU[7:0];
        flagC    = sumU[8];
        flagV    = addOvf(opA, opB);
      end
      FN_SUB: begin
        r16[7:0] = diffU[7:0];
        flagC    = diffU[8];
        flagV    = subOvf(opA, opB);
      end
      FN_MUL: begin
        r16   = {8'd0, opA} * {8'd0, opB};
        flagC = |r16[15:8];
      end
      FN_AND:  r16[7:0] = opA & opB;
      FN_OR:   r16[7:0] = opA | opB;
      FN_XOR:  r16[7:0] = opA ^ opB;
      FN_NOT:  r16[7:0] = ~opA;
      FN_NAND: r16[7:0] = ~(opA & opB);
      FN_NOR:  r16[7:0] = ~(opA | opB);
      FN_XNOR: r16[7:0] = ~(opA ^ opB);
      FN_SHL: begin
        r16[7:0] = {opA[6:0], 1'b0};
        flagC    = opA[7];
      end
      FN_SHR: begin
        r16[7:0] = {1'b0, opA[7:1]};
        flagC    = opA[0];
      end
      FN_INC: begin
        r16[7:0] = opA + 8'd1;
        flagC    = (opA == 8'hFF);
        flagV    = (opA == 8'h7F);
      end
      FN_DEC: begin
        r16[7:0] = opA - 8'd1;
        flagC    = (opA == 8'h00);
        flagV    = (opA == 8'h80);
      end
      FN_CMP: begin
        r16[7:0] = opA;
        flagC    = diffU[8];
        flagV    = subOvf(opA, opB);
      end
      FN_PASS: r16[7:0] = opA;
      default: r16 = '0;
    endcase

    flagZ = (r16[7:0] == 8'h00);
    flagN = r16[7];
    if (dp.alu_fsl == FN_MUL) begin
      flagZ = (r16 == 16'h0000);
      flagN = r16[15];
    end else if (dp.alu_fsl == FN_CMP) begin
      flagZ = (opA == opB);
      flagN = diffU[7];
    end
  end

  assign dp.result_low = r16[7:0];
  assign dp.mul_high   = r16[15:8];
  assign dp.alu_sreg   = {flagC, flagZ, flagN, flagV};

  // ---------------------------------------------------------------------------
  // Program counter: jump beats hold; free-run wraps 255 -> 0.
  // ---------------------------------------------------------------------------
  logic [7:0] pcCur_p1;
  logic [7:0] pcNext;

  always_comb begin
    if (dp.jump)      pcNext = dp.jump_line;
    else if (dp.hold) pcNext = pcCur_p1;
    else              pcNext = pcCur_p1 + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) pcCur_p1 <= '0;
    else     pcCur_p1 <= pcNext;
  end

  assign dp.pc_current = pcCur_p1;
  assign dp.pc_next    = pcNext;

endmodule

// File: tb/tb_hephaestus_exec_datapath.sv
// Scoreboard bench for hephaestus_exec_datapath: expectations are queued when
// stimulus is applied and compared when the corresponding outputs appear.
module tb_hephaestus_exec_datapath;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hephaestus_exec_datapath_if bus ();

  hephaestus_exec_datapath dut (
    .clk (clk),
    .rst (rst),
    .dp  (bus.slave)
  );

  typedef struct {
    string       tag;
    int          kind;
    logic [15:0] exp;
  } sbEntry_t;

  sbEntry_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference state
  logic [7:0] mGpr [8];
  logic [7:0] mRa, mRb, mPc;
  bit         pcKnown = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observe(input int kind);
    case (kind)
      0: return {8'd0, bus.ra_data};
      1: return {8'd0, bus.rb_data};
      2: return {8'd0, bus.pc_current};
      3: return {8'd0, bus.result_low};
      4: return {8'd0, bus.mul_high};
      5: return {12'd0, bus.alu_sreg};
      default: return {8'd0, bus.pc_next};
    endcase
  endfunction

  task automatic push(input string tag, input int kind, input logic [15:0] exp);
    sbEntry_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain();
    while (sb.size() > 0) begin
      sbEntry_t e;
      e = sb.pop_front();
      chk(e.tag, observe(e.kind), e.exp);
    end
  endtask

  // One clock edge with the currently driven inputs; the model predicts the
  // registered outputs, which are compared just after the edge.
  task automatic cycle(input string tag);
    logic [7:0] nRa, nRb, nPc;
    #1;
    if (!rst && pcKnown) begin
      nPc = bus.jump ? bus.jump_line : (bus.hold ? mPc : mPc + 8'd1);
      push({tag, "_pcnext"}, 6, {8'd0, nPc});
      drain();
    end
    if (rst) begin
      for (int i = 0; i < 8; i++) mGpr[i] = 8'h00;
      mRa = 0; mRb = 0; mPc = 0; pcKnown = 1;
    end else begin
      nRa = bus.read_en ? mGpr[bus.ra_num] : mRa;
      nRb = bus.read_en ? mGpr[bus.rb_num] : mRb;
      if (bus.write_en) begin
        mGpr[bus.rc_num] = bus.rc_in;
        if (bus.write_high) mGpr[(int'(bus.rc_num) + 1) % 8] = bus.mul_high_in;
      end
      mRa = nRa; mRb = nRb;
      mPc = bus.jump ? bus.jump_line : (bus.hold ? mPc : mPc + 8'd1);
    end
    push({tag, "_ra"}, 0, {8'd0, mRa});
    push({tag, "_rb"}, 1, {8'd0, mRb});
    push({tag, "_pc"}, 2, {8'd0, mPc});
    @(posedge clk);
    #1;
    drain();
  endtask

  function automatic void aluModel(input int a, input int b, input int f,
                                   output int lo, output int hi, output int fl);
    int r, c, z, n, v, sa, sbv, sr, full;
    sa  = (a >= 128) ? a - 256 : a;
    sbv = (b >= 128) ? b - 256 : b;
    r = 0; c = 0; v = 0; hi = 0;
    case (f)
      0:  begin r = a + b; c = (r > 255); sr = sa + sbv; v = (sr > 127 || sr < -128); r = r & 255; end
      1:  begin r = (a - b) & 255; c = (a < b); sr = sa - sbv; v = (sr > 127 || sr < -128); end
      2:  begin full = a * b; r = full & 255; hi = full >> 8; c = (hi != 0); end
      3:  r = a & b;
      4:  r = a | b;
      5:  r = a ^ b;
      6:  r = (~a) & 255;
      7:  r = (~(a & b)) & 255;
      8:  r = (~(a | b)) & 255;
      9:  r = (~(a ^ b)) & 255;
      10: begin r = (a << 1) & 255; c = (a >= 128); end
      11: begin r = a >> 1; c = a & 1; end
      12: begin r = (a + 1) & 255; c = (a == 255); v = (a == 127); end
      13: begin r = (a + 255) & 255; c = (a == 0); v = (a == 128); end
      14: begin r = a; c = (a < b); sr = sa - sbv; v = (sr > 127 || sr < -128); end
      default: r = a;
    endcase
    z = (r == 0);
    n = (r >= 128);
    if (f == 2) begin z = (a * b == 0); n = (hi >= 128); end
    if (f == 14) begin z = (a == b); n = (((a - b) & 255) >= 128); end
    lo = r;
    fl = (c << 3) | (z << 2) | (n << 1) | v;
  endfunction

  task automatic aluCase(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] f, input logic [7:0] eLo, input logic [7:0] eHi,
                         input logic [3:0] eFl);
    bus.operand_a = a; bus.operand_b = b; bus.alu_fsl = f;
    push({tag, "_low"}, 3, {8'd0, eLo});
    push({tag, "_high"}, 4, {8'd0, eHi});
    push({tag, "_flags"}, 5, {12'd0, eFl});
    #1;
    drain();
  endtask

  task automatic idle();
    bus.read_en = 0; bus.write_en = 0; bus.write_high = 0;
    bus.jump = 0; bus.hold = 0;
  endtask

  initial begin
    int lo, hi, fl;
    logic [7:0] a, b;
    logic [3:0] f;
    rst = 1;
    idle();
    bus.ra_num = 0; bus.rb_num = 0; bus.rc_num = 0; bus.rc_in = 0; bus.mul_high_in = 0;
    bus.operand_a = 0; bus.operand_b = 0; bus.alu_fsl = 0; bus.jump_line = 0;
    for (int i = 0; i < 8; i++) mGpr[i] = 8'hxx;
    mRa = 'x; mRb = 'x; mPc = 'x;

    @(posedge clk); #1;
    cycle("reset");
    rst = 0;

    bus.read_en = 1; bus.ra_num = 3; bus.rb_num = 5;
    cycle("read_after_reset");

    // Write 0x5A to r2 while reading r2 on the same edge: old value expected.
    bus.write_en = 1; bus.rc_num = 2; bus.rc_in = 8'h5A; bus.ra_num = 2; bus.rb_num = 2;
    cycle("rdw_same_edge");
    bus.write_en = 0;
    cycle("read_r2");

    aluCase("mul_ff_02", 8'hFF, 8'h02, 4'h2, 8'hFE, 8'h01, 4'b1000);
    bus.write_en = 1; bus.write_high = 1; bus.rc_num = 7; bus.rc_in = 8'hFE;
    bus.mul_high_in = 8'h01; bus.read_en = 0;
    cycle("wide_write");
    idle();
    bus.read_en = 1; bus.ra_num = 7; bus.rb_num = 0;
    cycle("read_wide");
    bus.write_en = 0; bus.write_high = 1; bus.rc_num = 3; bus.rc_in = 8'h11; bus.read_en = 0;
    cycle("high_no_en");
    bus.write_high = 0; bus.read_en = 1; bus.ra_num = 3; bus.rb_num = 4;
    cycle("read_high_no_en");

    aluCase("add_7f_01", 8'h7F, 8'h01, 4'h0, 8'h80, 8'h00, 4'b0011);
    aluCase("add_ff_01", 8'hFF, 8'h01, 4'h0, 8'h00, 8'h00, 4'b1100);
    aluCase("sub_03_05", 8'h03, 8'h05, 4'h1, 8'hFE, 8'h00, 4'b1010);
    aluCase("cmp_09_09", 8'h09, 8'h09, 4'hE, 8'h09, 8'h00, 4'b0100);
    aluCase("mul_zero",  8'h00, 8'h37, 4'h2, 8'h00, 8'h00, 4'b0100);
    aluCase("dec_zero",  8'h00, 8'h00, 4'hD, 8'hFF, 8'h00, 4'b1010);
    aluCase("shr_odd",   8'h81, 8'h00, 4'hB, 8'h40, 8'h00, 4'b1000);
    for (int i = 0; i < 48; i++) begin
      a = 8'($urandom); b = 8'($urandom); f = 4'(i % 16);
      aluModel(int'(a), int'(b), int'(f), lo, hi, fl);
      aluCase("alu_rand", a, b, f, 8'(lo), 8'(hi), 4'(fl));
    end

    // PC sequencing
    idle(); rst = 1;
    cycle("pc_reset");
    rst = 0;
    cycle("pc_run1"); cycle("pc_run2"); cycle("pc_run3");
    bus.hold = 1;
    cycle("pc_hold1"); cycle("pc_hold2");
    bus.jump = 1; bus.jump_line = 8'h40;
    cycle("pc_jump_hold");
    bus.hold = 0; bus.jump_line = 8'hFF;
    cycle("pc_jump_ff");
    bus.jump = 0;
    cycle("pc_wrap");

    // Random register-file and PC traffic
    for (int i = 0; i < 60; i++) begin
      bus.read_en = 1'($urandom); bus.write_en = 1'($urandom); bus.write_high = 1'($urandom);
      bus.ra_num = 3'($urandom); bus.rb_num = 3'($urandom); bus.rc_num = 3'($urandom);
      bus.rc_in = 8'($urandom); bus.mul_high_in = 8'($urandom);
      bus.hold = 1'($urandom); bus.jump = ($urandom_range(0, 7) == 0);
      bus.jump_line = 8'($urandom);
      cycle("rand_rf");
    end

    // Reset while write and jump are requested: both discarded.
    idle();
    rst = 1; bus.write_en = 1; bus.rc_num = 4; bus.rc_in = 8'hAA;
    bus.jump = 1; bus.jump_line = 8'h77;
    cycle("reset_mid");
    rst = 0; idle();
    for (int r = 0; r < 8; r += 2) begin
      bus.read_en = 1; bus.ra_num = 3'(r); bus.rb_num = 3'(r + 1);
      cycle("read_after_mid_reset");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
